rsenc_gf_kit: RTL and testbench

Primitive kit for the Reed-Solomon telemetry encoder, with three independent functions in one block. It provides a GF(2^MM) constant/variable multiplier used by every encoder tap, a codeword symbol timer with terminal-count decode used by the encoder state machine, and a parameterised single-bit delay line that aligns the ready flag with encoder latency.

---
 rtl/rsenc_pkg.sv | 39 +++
 rtl/rsenc_gf_mul.sv | 25 ++
 rtl/rsenc_gf_kit.sv | 109 ++++++++++
 tb/tb_rsenc_gf_kit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsenc_pkg.sv
// Shared constants and the GF(2^m) shift-and-add multiply used by the
// Reed-Solomon encoder primitives.
package rsenc_pkg;

   localparam int RSENC_MM_MAX = 8;

   localparam logic [8:0] RSENC_POLY_CCSDS = 9'h187;
   localparam logic [4:0] RSENC_POLY_MM4   = 5'h13;

   // Walks b MSB-first; each step doubles the accumulator, folds bit mm back
   // through the generator, then adds a when the current b bit is set.
   function automatic logic [RSENC_MM_MAX-1:0] gf_mul(
      input logic [RSENC_MM_MAX-1:0] a,
      input logic [RSENC_MM_MAX-1:0] b,
      input logic [RSENC_MM_MAX:0]   poly,
      input int                      mm
   );
      logic [RSENC_MM_MAX:0]   acc;
      logic [RSENC_MM_MAX:0]   top;
      logic [RSENC_MM_MAX-1:0] bits;
      acc  = {(RSENC_MM_MAX+1){1'b0}};
      top  = {{RSENC_MM_MAX{1'b0}}, 1'b1} << mm;
      bits = b << (RSENC_MM_MAX - mm);
      for (int i = 0; i < RSENC_MM_MAX; i++) begin
         if (i < mm) begin
            acc = acc << 1;
            if ((acc & top) != {(RSENC_MM_MAX+1){1'b0}}) begin
               acc = acc ^ poly;
            end
            if (bits[RSENC_MM_MAX-1]) begin
               acc = acc ^ {1'b0, a};
            end
            bits = bits << 1;
         end
      end
      return acc[RSENC_MM_MAX-1:0];
   endfunction

endpackage

// File: rtl/rsenc_gf_mul.sv
// Combinational GF(2^MM) multiplier, one instance per encoder tap.
module rsenc_gf_mul
   import rsenc_pkg::*;
#(
   parameter int          MM        = 8,
   parameter logic [MM:0] PRIM_POLY = RSENC_POLY_CCSDS
) (
   input  logic [MM-1:0] a,
   input  logic [MM-1:0] b,
   output logic [MM-1:0] prod
);

   logic [RSENC_MM_MAX-1:0] a_ext;
   logic [RSENC_MM_MAX-1:0] b_ext;
   logic [RSENC_MM_MAX:0]   poly_ext;

   // Operands are widened to the package maximum; the product always fits in MM bits.
   always_comb begin
      a_ext    = RSENC_MM_MAX'(a);
      b_ext    = RSENC_MM_MAX'(b);
      poly_ext = (RSENC_MM_MAX+1)'(PRIM_POLY);
      prod     = MM'(gf_mul(a_ext, b_ext, poly_ext, MM));
   end

endmodule

// File: rtl/rsenc_gf_kit.sv
// Reed-Solomon encoder primitive kit: GF multiplier, symbol timer, bit delay line.
// Define RSENC_GF_PIPE_EN to register the multiplier output.
module rsenc_gf_kit
   import rsenc_pkg::*;
#(
   parameter int          MM        = 8,
   parameter logic [MM:0] PRIM_POLY = RSENC_POLY_CCSDS,
   parameter int          WIDTH     = 8,
   parameter int          DCVALUE   = 253,
   parameter int          BUILD_DC  = 1,
   parameter int          DELAY     = 2
) (
   input  logic             clk,
   input  logic             grst,
   input  logic             rst,
   input  logic             clkEn,
   input  logic [MM-1:0]    a,
   input  logic [MM-1:0]    b,
   output logic [MM-1:0]    prod,
   input  logic             cntEn,
   output logic [WIDTH-1:0] Q,
   output logic             dc,
   input  logic             inp,
   output logic             outp
);

   logic [MM-1:0] prod_comb;

   rsenc_gf_mul #(
      .MM        (MM),
      .PRIM_POLY (PRIM_POLY)
   ) u_gf_mul (
      .a    (a),
      .b    (b),
      .prod (prod_comb)
   );

`ifdef RSENC_GF_PIPE_EN
   // Product register: cleared by either reset, holds while the clock enable is low.
   always_ff @(posedge clk or posedge grst) begin
      if (grst) begin
         prod <= {MM{1'b0}};
      end else if (clkEn) begin
         if (rst) begin
            prod <= {MM{1'b0}};
         end else begin
            prod <= prod_comb;
         end
      end
   end
`else
   assign prod = prod_comb;
`endif

   // Symbol timer: clear beats count, free-running wrap at all-ones.
   always_ff @(posedge clk or posedge grst) begin
      if (grst) begin
         Q <= {WIDTH{1'b0}};
      end else if (clkEn) begin
         if (rst) begin
            Q <= {WIDTH{1'b0}};
         end else if (cntEn) begin
            Q <= Q + WIDTH'(1'b1);
         end
      end
   end

   generate
      if (BUILD_DC == 1) begin : g_dc
         assign dc = (Q == WIDTH'(DCVALUE));
      end else begin : g_no_dc
         assign dc = 1'b0;
      end
   endgenerate

   generate
      if (DELAY == 0) begin : g_dly_none
         assign outp = inp;
      end else begin : g_dly
         logic [DELAY-1:0] stages;
         logic [DELAY-1:0] shifted;

         // Next chain contents: inp enters stage 0, everything moves one toward outp.
         always_comb begin
            shifted    = {DELAY{1'b0}};
            shifted[0] = inp;
            for (int i = 1; i < DELAY; i++) begin
               shifted[i] = stages[i-1];
            end
         end

         // Delay chain register; only enabled edges advance it.
         always_ff @(posedge clk or posedge grst) begin
            if (grst) begin
               stages <= {DELAY{1'b0}};
            end else if (clkEn) begin
               if (rst) begin
                  stages <= {DELAY{1'b0}};
               end else begin
                  stages <= shifted;
               end
            end
         end

         assign outp = stages[DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_rsenc_gf_kit.sv
// Self-checking bench for rsenc_gf_kit: an MM=8/DELAY=3 instance and an
// MM=4/BUILD_DC=0/DELAY=0 instance sharing clock, resets and enables.
module tb_rsenc_gf_kit;

   localparam int D8 = 3;

   logic       clk = 1'b0;
   logic       grst, rst, clkEn, cntEn, inp;
   logic [7:0] a8, b8, prod8, q8;
   logic       dc8, outp8;
   logic [3:0] a4, b4, prod4;
   logic [7:0] q4;
   logic       dc4, outp4;

   always #5 clk = ~clk;

   rsenc_gf_kit #(.MM(8), .PRIM_POLY(9'h187), .WIDTH(8), .DCVALUE(253),
                  .BUILD_DC(1), .DELAY(D8)) dut8 (
      .clk(clk), .grst(grst), .rst(rst), .clkEn(clkEn),
      .a(a8), .b(b8), .prod(prod8), .cntEn(cntEn), .Q(q8), .dc(dc8),
      .inp(inp), .outp(outp8));

   rsenc_gf_kit #(.MM(4), .PRIM_POLY(5'h13), .WIDTH(8), .DCVALUE(253),
                  .BUILD_DC(0), .DELAY(0)) dut4 (
      .clk(clk), .grst(grst), .rst(rst), .clkEn(clkEn),
      .a(a4), .b(b4), .prod(prod4), .cntEn(cntEn), .Q(q4), .dc(dc4),
      .inp(inp), .outp(outp4));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Carry-less product followed by polynomial long division.
   function automatic int ref_mul(input int x, input int y, input int poly, input int mm);
      int p = 0;
      for (int i = 0; i < mm; i++) if (((y >> i) & 1) == 1) p = p ^ (x << i);
      for (int k = 2*mm-2; k >= mm; k--) if (((p >> k) & 1) == 1) p = p ^ (poly << (k - mm));
      return p;
   endfunction

   // Model: counter value, enabled-edge numbering, input history, last clear point.
   int m_q = 0;
   int en_count = 0;
   int last_clear = 0;
   bit hist[$];

   function automatic bit exp_outp();
      int src = en_count - (D8 - 1);
      if (src > last_clear) return hist[src-1];
      return 1'b0;
   endfunction

   task automatic tick();
      if (clkEn) begin
         en_count++;
         hist.push_back(inp);
         if (rst) begin
            m_q = 0;
            last_clear = en_count;
         end else if (cntEn) begin
            m_q = (m_q + 1) % 256;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_mul();
`ifdef RSENC_GF_PIPE_EN
      tick();
`else
      #1;
`endif
   endtask

   typedef struct {
      logic [7:0] a8, b8, e8;
      logic [3:0] a4, b4, e4;
   } mul_vec_t;

   mul_vec_t   tbl[6];
   logic [7:0] res [0:255][0:255];

   initial begin
      tbl[0] = '{a8:8'h02, b8:8'h80, e8:8'h87, a4:4'h8, b4:4'h2, e4:4'h3};
      tbl[1] = '{a8:8'h02, b8:8'h02, e8:8'h04, a4:4'hF, b4:4'hF, e4:4'hA};
      tbl[2] = '{a8:8'h5A, b8:8'h01, e8:8'h5A, a4:4'h1, b4:4'h7, e4:4'h7};
      tbl[3] = '{a8:8'h00, b8:8'hFF, e8:8'h00, a4:4'h0, b4:4'h9, e4:4'h0};
      tbl[4] = '{a8:8'h01, b8:8'h01, e8:8'h01, a4:4'h5, b4:4'h0, e4:4'h0};
      tbl[5] = '{a8:8'hFF, b8:8'h01, e8:8'hFF, a4:4'h3, b4:4'h1, e4:4'h3};

      grst = 1'b1; rst = 1'b0; clkEn = 1'b0; cntEn = 1'b0; inp = 1'b0;
      a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
      #12;
      check("reset_q", q8, 0);
      check("reset_dc", dc8, 0);
      check("reset_outp", outp8, 0);
      check("reset_dc4", dc4, 0);
      check("reset_q4", q4, 0);
`ifdef RSENC_GF_PIPE_EN
      check("reset_prod", prod8, 0);
`endif
      @(negedge clk);
      grst = 1'b0;
      @(posedge clk);
      #1;

      clkEn = 1'b1;
      foreach (tbl[i]) begin
         a8 = tbl[i].a8; b8 = tbl[i].b8; a4 = tbl[i].a4; b4 = tbl[i].b4;
         apply_mul();
         check($sformatf("mul8_tbl%0d", i), prod8, tbl[i].e8);
         check($sformatf("mul4_tbl%0d", i), prod4, tbl[i].e4);
      end

      for (int x = 0; x < 256; x++) begin
         for (int y = 0; y < 256; y++) begin
            a8 = 8'(x); b8 = 8'(y);
            a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
            apply_mul();
            res[x][y] = prod8;
            check("mul8_ref", prod8, ref_mul(x, y, 'h187, 8));
            check("mul4_ref", prod4, ref_mul(int'(a4), int'(b4), 'h13, 4));
         end
      end
      for (int x = 0; x < 256; x++)
         for (int y = x + 1; y < 256; y++)
            check("mul8_commute", res[x][y], res[y][x]);

      // Timer: clear, then count through 253 and the wrap.
      rst = 1'b1; cntEn = 1'b0;
      tick();
      check("tmr_clear", q8, 0);
      rst = 1'b0; cntEn = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         tick();
         check("tmr_count", q8, k % 256);
         check("tmr_dc", dc8, (k % 256) == 253);
         check("tmr_dc_off", dc4, 0);
      end
      rst = 1'b1;
      tick();
      check("tmr_rst_cnt", q8, 0);
      rst = 1'b0;
      tick(); tick();
      clkEn = 1'b0;
      tick(); tick(); tick();
      check("tmr_hold", q8, 2);
      clkEn = 1'b1;

      // Delay line: single pulse, then a pulse with a two-clock enable gap.
      cntEn = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; inp = 1'b1;
      tick();
      check("dly_e1", outp8, 0);
      check("dly0_comb", outp4, 1);
      inp = 1'b0;
      tick();
      check("dly_e2", outp8, 0);
      tick();
      check("dly_e3", outp8, 1);
      tick();
      check("dly_e4", outp8, 0);
      inp = 1'b1;
      tick();
      inp = 1'b0;
      tick();
      clkEn = 1'b0;
      tick();
      check("dly_gap1", outp8, 0);
      tick();
      check("dly_gap2", outp8, 0);
      clkEn = 1'b1;
      tick();
      check("dly_gap_out", outp8, 1);
      tick();
      check("dly_gap_end", outp8, 0);

      inp = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; inp = 1'b0;
      tick(); tick();
      check("dly_rst_wins", outp8, 0);

      // Asynchronous global reset mid-operation.
      inp = 1'b1; cntEn = 1'b1;
      tick(); tick(); tick();
      check("grst_pre_q", q8, 3);
      check("grst_pre_outp", outp8, 1);
      #2;
      grst = 1'b1;
      m_q = 0;
      last_clear = en_count;
      #1;
      check("grst_q", q8, 0);
      check("grst_outp", outp8, 0);
`ifdef RSENC_GF_PIPE_EN
      check("grst_prod", prod8, 0);
`endif
      #1;
      grst = 1'b0;
      inp = 1'b0;
      a8 = 8'h02; b8 = 8'h80;
      tick();
      check("grst_q_after", q8, 1);
      check("grst_prod_after", prod8, 8'h87);

      // Randomized enables, clears and delay-line data against the model.
      for (int n = 0; n < 400; n++) begin
         clkEn = ($urandom_range(0, 3) != 0);
         cntEn = ($urandom_range(0, 3) != 0);
         rst   = ($urandom_range(0, 19) == 0);
         inp   = 1'($urandom_range(0, 1));
         tick();
         check("rnd_q", q8, m_q);
         check("rnd_q4", q4, m_q);
         check("rnd_dc", dc8, m_q == 253);
         check("rnd_outp", outp8, exp_outp());
         check("rnd_outp4", outp4, inp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
